// File: rtl/pipe_stage_skid.sv
// Two-entry skid-buffered pipeline register between core stages.
// Main register drives the outputs; skid absorbs one entry under backpressure.
module pipe_stage_skid #(
    parameter int DATA_W = 32,
    parameter int NFIELD = 3,
    parameter int CTRL_W = 7,
    parameter int RD_W   = 5,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     clr_stats,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CTRL_W-1:0]        in_ctrl,
    input  logic [RD_W-1:0]          in_rd,
    input  logic [NFIELD*DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CTRL_W-1:0]        out_ctrl,
    output logic [RD_W-1:0]          out_rd,
    output logic [NFIELD*DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]         stall_cnt
);

    localparam int DW = NFIELD * DATA_W;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t            state;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [RD_W-1:0]   skid_rd;
    logic [DW-1:0]     skid_data;

    logic in_xfer;
    logic out_xfer;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    // Occupancy FSM; main and skid registers plus both handshake flags are flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_ctrl  <= '0;
            out_rd    <= '0;
            out_data  <= '0;
            skid_ctrl <= '0;
            skid_rd   <= '0;
            skid_data <= '0;
        end else if (flush) begin
            // Bubble ctrl is cleared so no write enable leaks downstream.
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_ctrl  <= '0;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        state     <= ONE;
                        out_valid <= 1'b1;
                        out_ctrl  <= in_ctrl;
                        out_rd    <= in_rd;
                        out_data  <= in_data;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        out_ctrl <= in_ctrl;
                        out_rd   <= in_rd;
                        out_data <= in_data;
                    end else if (in_xfer) begin
                        state     <= TWO;
                        in_ready  <= 1'b0;
                        skid_ctrl <= in_ctrl;
                        skid_rd   <= in_rd;
                        skid_data <= in_data;
                    end else if (out_xfer) begin
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                        out_ctrl  <= '0;
                    end
                end
                TWO: begin
                    if (out_xfer) begin
                        state    <= ONE;
                        in_ready <= 1'b1;
                        out_ctrl <= skid_ctrl;
                        out_rd   <= skid_rd;
                        out_data <= skid_data;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    out_ctrl  <= '0;
                end
            endcase
        end
    end

    // Saturating backpressure counter; clear wins, flush leaves it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (clr_stats) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: queue-based reference model, directed
// scenarios with literal expectations, then randomized traffic.
module tb_pipe_stage_skid;

    localparam int DW = 96;

    typedef struct {
        logic [6:0]    ctrl;
        logic [4:0]    rd;
        logic [DW-1:0] data;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          clr_stats = 1'b0;
    logic          in_valid = 1'b0;
    logic [6:0]    in_ctrl = '0;
    logic [4:0]    in_rd = '0;
    logic [DW-1:0] in_data = '0;
    logic          out_ready = 1'b0;

    logic          in_ready, out_valid;
    logic [6:0]    out_ctrl;
    logic [4:0]    out_rd;
    logic [DW-1:0] out_data;
    logic [15:0]   stall_cnt;

    logic          in_ready4, out_valid4;
    logic [6:0]    out_ctrl4;
    logic [4:0]    out_rd4;
    logic [DW-1:0] out_data4;
    logic [3:0]    stall_cnt4;

    int n_chk = 0;
    int n_fail = 0;

    ent_t q[$];
    int   m_cnt = 0;
    int   m_cnt4 = 0;
    bit   m_ix, m_ox;

    always #5 clk = ~clk;

    pipe_stage_skid dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .clr_stats(clr_stats),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
        .in_rd(in_rd), .in_data(in_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_ctrl(out_ctrl), .out_rd(out_rd),
        .out_data(out_data), .stall_cnt(stall_cnt)
    );

    pipe_stage_skid #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .clr_stats(clr_stats),
        .in_valid(in_valid), .in_ready(in_ready4), .in_ctrl(in_ctrl),
        .in_rd(in_rd), .in_data(in_data), .out_valid(out_valid4),
        .out_ready(out_ready), .out_ctrl(out_ctrl4), .out_rd(out_rd4),
        .out_data(out_data4), .stall_cnt(stall_cnt4)
    );

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: an ordered queue of at most two held entries.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_cnt  = 0;
            m_cnt4 = 0;
        end else begin
            m_ix = in_valid && (q.size() < 2);
            m_ox = (q.size() > 0) && out_ready;
            if (clr_stats) begin
                m_cnt  = 0;
                m_cnt4 = 0;
            end else if ((q.size() > 0) && !out_ready) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt4 < 15) m_cnt4++;
            end
            if (flush) begin
                q.delete();
            end else begin
                if (m_ox) void'(q.pop_front());
                if (m_ix) q.push_back('{in_ctrl, in_rd, in_data});
            end
        end
    end

    // Every cycle: outputs of both instances against the model.
    always @(negedge clk) begin
        chk("out_valid", out_valid, q.size() > 0);
        chk("in_ready", in_ready, q.size() < 2);
        chk("out_ctrl", out_ctrl, (q.size() > 0) ? q[0].ctrl : 7'h0);
        chk("stall_cnt", stall_cnt, m_cnt[15:0]);
        chk("stall_cnt4", stall_cnt4, m_cnt4[3:0]);
        chk("out_valid4", out_valid4, q.size() > 0);
        if (q.size() > 0) begin
            chk("out_rd", out_rd, q[0].rd);
            chk("out_data", out_data, q[0].data);
            chk("out_data4", out_data4, q[0].data);
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic v, input logic [6:0] c,
                         input logic [4:0] r, input logic [DW-1:0] d);
        in_valid = v;
        in_ctrl  = c;
        in_rd    = r;
        in_data  = d;
    endtask

    logic [DW-1:0] da, db, dc, exp_d;

    initial begin
        da = {32'hA3, 32'hA2, 32'hA1};
        db = {32'hB3, 32'hB2, 32'hB1};
        dc = {32'hC3, 32'hC2, 32'hC1};

        step(2);
        rst_n = 1'b1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_ctrl", out_ctrl, 7'h0);
        chk("rst_stall", stall_cnt, 16'h0);

        // Streaming at full rate
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 7'h45, 5'd5, {32'h30, 32'h20, 32'h10 + 32'(i)});
            step();
            exp_d = {32'h30, 32'h20, 32'h10 + 32'(i)};
            chk("stream_valid", out_valid, 1'b1);
            chk("stream_data", out_data, exp_d);
            chk("stream_rd", out_rd, 5'd5);
            chk("stream_ctrl", out_ctrl, 7'h45);
            chk("stream_in_ready", in_ready, 1'b1);
        end
        drive(1'b0, 7'h0, 5'd0, '0);
        step();
        clr_stats = 1'b1;
        step();
        clr_stats = 1'b0;

        // Skid
        out_ready = 1'b0;
        drive(1'b1, 7'h11, 5'd1, da);
        step();
        chk("skid_a_head", out_data, da);
        drive(1'b1, 7'h22, 5'd2, db);
        step();
        chk("skid_in_ready", in_ready, 1'b0);
        chk("skid_hold_a", out_data, da);
        drive(1'b0, 7'h0, 5'd0, '0);
        out_ready = 1'b1;
        step();
        chk("skid_b_head", out_data, db);
        chk("skid_b_ctrl", out_ctrl, 7'h22);
        step();
        chk("skid_empty", out_valid, 1'b0);
        chk("skid_stall", stall_cnt, 16'd1);

        // Flush from TWO with a live input
        out_ready = 1'b0;
        drive(1'b1, 7'h11, 5'd1, da);
        step();
        drive(1'b1, 7'h22, 5'd2, db);
        step();
        drive(1'b1, 7'h33, 5'd3, dc);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_valid", out_valid, 1'b0);
        chk("flush_ctrl", out_ctrl, 7'h0);
        chk("flush_in_ready", in_ready, 1'b1);
        drive(1'b0, 7'h0, 5'd0, '0);
        out_ready = 1'b1;
        step(2);
        chk("flush_no_c", out_valid, 1'b0);

        // Saturation
        clr_stats = 1'b1;
        step();
        clr_stats = 1'b0;
        out_ready = 1'b0;
        drive(1'b1, 7'h44, 5'd4, da);
        step();
        drive(1'b0, 7'h0, 5'd0, '0);
        step(20);
        chk("sat_cnt4", stall_cnt4, 4'd15);
        chk("sat_cnt16", stall_cnt, 16'd20);
        clr_stats = 1'b1;
        step();
        clr_stats = 1'b0;
        chk("clr_cnt4", stall_cnt4, 4'd0);
        chk("clr_cnt16", stall_cnt, 16'd0);
        out_ready = 1'b1;
        step();

        // Reset between edges while in TWO
        out_ready = 1'b0;
        drive(1'b1, 7'h11, 5'd1, da);
        step();
        drive(1'b1, 7'h22, 5'd2, db);
        step();
        drive(1'b0, 7'h0, 5'd0, '0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 1'b0);
        chk("arst_in_ready", in_ready, 1'b1);
        chk("arst_ctrl", out_ctrl, 7'h0);
        chk("arst_stall", stall_cnt, 16'h0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 7'h55, 5'd7, dc);
        step();
        chk("post_rst_data", out_data, dc);
        chk("post_rst_valid", out_valid, 1'b1);
        drive(1'b0, 7'h0, 5'd0, '0);
        step();

        // Bubble: ctrl must stay zero with no valid input
        drive(1'b0, 7'h7F, 5'd0, '0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bubble_ctrl", out_ctrl, 7'h0);
        end

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom % 4) != 0, 7'($urandom), 5'($urandom),
                  {$urandom, $urandom, $urandom});
            out_ready = ($urandom % 3) != 0;
            flush     = ($urandom % 40) == 0;
            clr_stats = ($urandom % 60) == 0;
            step();
        end
        flush = 1'b0;
        clr_stats = 1'b0;
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- DATA_W, 32: width of one datapath field.
- NFIELD, 3: number of datapath fields carried, e.g. ALU result, store data and PC+4.
- CTRL_W, 7: control bundle width, e.g. funct3, RegWrite, MemWrite and ResultSrc.
- RD_W, 5: destination register index width.
- CNT_W, 16: stall counter width.

REQ-002 The block SHALL use one clock, clk; reset is asynchronous and active-low, rst_n. Ports (name, direction, width, meaning):
- clk, in, 1: clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- flush, in, 1: synchronous kill of all held entries.
- clr_stats, in, 1: synchronous clear of stall_cnt.
- in_valid, in, 1: upstream stage presents an entry.
- in_ready, out, 1: stage can accept an entry.
- in_ctrl, in, CTRL_W: control bundle.
- in_rd, in, RD_W: destination register index.
- in_data, in, NFIELD*DATA_W: packed datapath fields, field 0 at the LSBs.
- out_valid, out, 1: entry presented downstream.
- out_ready, in, 1: downstream consumes this cycle.
- out_ctrl, out, CTRL_W: control bundle of the head entry.
- out_rd, out, RD_W: destination index of the head entry.
- out_data, out, NFIELD*DATA_W: datapath fields of the head entry.
- stall_cnt, out, CNT_W: saturating count of backpressure cycles.

Function
REQ-003 The block SHALL act as a 2-entry skid-buffered pipeline register: a main register drives the outputs, and a skid register holds one extra entry.
REQ-004 The state SHALL be one of EMPTY (0 entries), ONE (main full) or TWO (main and skid full).
REQ-005 A transfer SHALL occur on a rising edge with valid and ready both high on that side.
REQ-006 in_ready SHALL be a registered signal, equal to 1 in EMPTY and ONE and 0 in TWO; it SHALL have no combinational path from out_ready.
REQ-007 out_valid SHALL be 1 exactly in ONE and TWO, driven directly from a flop.
REQ-008 From EMPTY, an input transfer SHALL load main and go to ONE: latency is 1 cycle, input edge to out_valid.
REQ-009 From ONE, transitions SHALL be:
- input and output both transfer: main loads the input, stay in ONE (throughput 1 entry per cycle).
- input only: skid loads the input, go to TWO.
- output only: go to EMPTY.
- neither: hold.
REQ-010 From TWO, an output transfer SHALL move skid into main and go to ONE; otherwise hold. No input is accepted in TWO.
REQ-011 Entries SHALL leave in arrival order; no entry is duplicated or dropped except by flush.
REQ-012 out_ctrl SHALL equal all-zeros whenever out_valid=0, so a bubble never asserts RegWrite or MemWrite downstream.
REQ-013 out_data and out_rd are don't-care when out_valid=0.
REQ-014 Flush SHALL have the highest priority:
- Any state goes to EMPTY on the next edge.
- The input presented in the flush cycle is discarded, even if in_valid and in_ready are both 1.
- An output transfer in the flush cycle still counts as consumed downstream.
- in_ready is 1 on the cycle after flush.
REQ-015 stall_cnt SHALL increment by 1 on each edge where out_valid=1 and out_ready=0, saturating at 2^CNT_W-1 with no wrap.
REQ-016 clr_stats SHALL zero stall_cnt on the next edge and take priority over the increment; flush SHALL NOT affect stall_cnt.
REQ-017 Data and control SHALL be held bit-exact while the stage stalls; no field is sign- or zero-extended.

Reset
REQ-018 While rst_n=0, the block SHALL asynchronously force:
- state to EMPTY;
- in_ready=1 and out_valid=0;
- out_ctrl, out_rd, out_data and stall_cnt to 0;
- the skid register to 0.
REQ-019 Reset asserted mid-operation SHALL discard all held entries with no downstream transfer; on the first edge after deassertion the block SHALL behave as EMPTY.

Verification
REQ-020 The bench SHALL cover these directed scenarios (stimulus -> required response):
- Streaming: out_ready=1; in_data fields 0x10, 0x20, 0x30, in_rd 5 and ctrl 0x45 applied on 4 consecutive cycles -> the same 4 entries appear, in order, 1 cycle later; in_ready stays 1.
- Skid: in ONE holding entry A, out_ready=0 and B applied -> TWO, in_ready=0; out_ready=1 for 2 cycles -> A then B delivered; state EMPTY; stall_cnt=1.
- Flush: in TWO, flush=1 with in_valid=1 carrying C -> next cycle out_valid=0, out_ctrl=0, in_ready=1; C never appears.
- Saturation: CNT_W=4, out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt=15 and holds; clr_stats=1 -> 0 next cycle.
- Reset mid-operation: rst_n pulled low between edges while in TWO -> outputs immediately show out_valid=0, in_ready=1, out_ctrl=0, stall_cnt=0.
- Bubble: in_valid=0 for 3 cycles in EMPTY with in_ctrl=0x7F -> out_ctrl remains 0 throughout.
